// File: rtl/cmd_pkg.sv
// Shared definitions for the command dispatcher: opcode and error-code
// constants, FSM state encoding, graphics-state payload layout and a
// unit-opcode decode helper.
package cmd_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned ERR_W  = 3;

    // Opcodes: units occupy OP_UNIT_BASE .. OP_UNIT_BASE+NUM_UNITS-1
    localparam logic [OP_W-1:0] OP_UNIT_BASE    = 8'h01;
    localparam logic [OP_W-1:0] OP_SET_COLOR    = 8'h10;
    localparam logic [OP_W-1:0] OP_SET_VIEWPORT = 8'h11;

    // Required payload lengths of the state-write opcodes
    localparam logic [LEN_W-1:0] LEN_SET_COLOR    = 16'd1;
    localparam logic [LEN_W-1:0] LEN_SET_VIEWPORT = 16'd4;

    // Error codes reported on err_code
    localparam logic [ERR_W-1:0] ERR_NONE       = 3'd0;
    localparam logic [ERR_W-1:0] ERR_UNKNOWN_OP = 3'd1;
    localparam logic [ERR_W-1:0] ERR_OVERSIZE   = 3'd2;
    localparam logic [ERR_W-1:0] ERR_BAD_LEN    = 3'd3;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT    = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        DRAIN    = 3'd2,
        DISPATCH = 3'd3,
        WAIT     = 3'd4
    } state_e;

    // Viewport register layout, xmin in the least significant word
    typedef struct packed {
        logic [WORD_W-1:0] ymax;
        logic [WORD_W-1:0] xmax;
        logic [WORD_W-1:0] ymin;
        logic [WORD_W-1:0] xmin;
    } viewport_t;

    // True when op addresses one of num_units action units
    function automatic logic is_unit_op(input logic [OP_W-1:0] op,
                                        input int unsigned     num_units);
        return (op >= OP_UNIT_BASE) &&
               (32'(op) < (32'(OP_UNIT_BASE) + num_units));
    endfunction

endpackage

// File: rtl/cmd_dispatch_if.sv
// Command word stream between the host command FIFO and the dispatcher.
//   cmd_valid : word valid (host -> dispatcher)
//   cmd_data  : 32-bit command word (host -> dispatcher)
//   cmd_ready : word accepted when valid && ready (dispatcher -> host)
interface cmd_dispatch_if;
    import cmd_pkg::*;

    logic              cmd_valid;
    logic [WORD_W-1:0] cmd_data;
    logic              cmd_ready;

    modport master (output cmd_valid, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, output cmd_ready);

endinterface

// File: rtl/cmd_watchdog.sv
// Done-wait watchdog: counts enabled cycles after a clear and flags
// expire during the TIMEOUT_CYCLES-th enabled cycle.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart the count (asserted the cycle before counting)
//   enable     : count this cycle
//   expire     : registered, high in the last allowed enabled cycle
//                (tied low when TIMEOUT_CYCLES is 0)
module cmd_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [CNT_W-1:0] count_q, count_d;
    logic             expire_q, expire_d;

    // Expire is registered off the next count, so it lines up with the
    // enabled cycle whose count equals LIMIT.
    always_comb begin
        count_d  = count_q;
        expire_d = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
        if ((TIMEOUT_CYCLES != 0) && (clear || enable)) begin
            expire_d = (count_d == CNT_W'(LIMIT));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            expire_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule

// File: rtl/cmd_dispatch.sv
// Command front-end: accepts header + payload words, buffers the payload,
// then starts an action unit or writes graphics-state registers.
//   clk, rst_n    : clock, async active-low reset
//   cmd           : command word stream (slave side)
//   unit_start    : one-hot single-cycle start pulse per unit
//   unit_done     : per-unit completion pulse
//   payload       : buffered payload, word i at [32i+31:32i]
//   payload_len   : length field of the current command
//   current_color : graphics-state colour
//   viewport      : {ymax, xmax, ymin, xmin}
//   busy          : high in any state but IDLE
//   err_valid     : single-cycle error pulse
//   err_code      : last error code, held until the next error
module cmd_dispatch
    import cmd_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD    = 6,
    parameter int unsigned NUM_UNITS      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        rst_n,
    cmd_dispatch_if.slave               cmd,
    output logic [NUM_UNITS-1:0]        unit_start,
    input  logic [NUM_UNITS-1:0]        unit_done,
    output logic [WORD_W*MAX_PAYLOAD-1:0] payload,
    output logic [LEN_W-1:0]            payload_len,
    output logic [WORD_W-1:0]           current_color,
    output logic [4*WORD_W-1:0]         viewport,
    output logic                        busy,
    output logic                        err_valid,
    output logic [ERR_W-1:0]            err_code
);

    state_e                                 state_q, state_d;
    logic [OP_W-1:0]                        opcode_q, opcode_d;
    logic [LEN_W-1:0]                       length_q, length_d;
    logic [LEN_W-1:0]                       count_q, count_d;
    logic [MAX_PAYLOAD-1:0][WORD_W-1:0]     payload_q, payload_d;
    logic [LEN_W-1:0]                       payload_len_q, payload_len_d;
    logic [WORD_W-1:0]                      color_q, color_d;
    viewport_t                              viewport_q, viewport_d;
    logic [NUM_UNITS-1:0]                   start_q, start_d;
    logic [NUM_UNITS-1:0]                   unit_sel_q, unit_sel_d;
    logic                                   ready_q, ready_d;
    logic                                   busy_q, busy_d;
    logic                                   err_valid_q, err_valid_d;
    logic [ERR_W-1:0]                       err_code_q, err_code_d;

    logic                                   hs_c;
    logic                                   done_hit_c;
    logic                                   wd_clear_c;
    logic                                   wd_enable_c;
    logic                                   wd_expire;

    assign hs_c        = cmd.cmd_valid && ready_q;
    assign done_hit_c  = |(unit_done & unit_sel_q);
    assign wd_clear_c  = (state_q == DISPATCH);
    assign wd_enable_c = (state_q == WAIT);

    cmd_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (wd_clear_c),
        .enable(wd_enable_c),
        .expire(wd_expire)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        length_d      = length_q;
        count_d       = count_q;
        payload_d     = payload_q;
        payload_len_d = payload_len_q;
        color_d       = color_q;
        viewport_d    = viewport_q;
        start_d       = '0;
        unit_sel_d    = unit_sel_q;
        err_valid_d   = 1'b0;
        err_code_d    = err_code_q;

        case (state_q)
            IDLE: begin
                if (hs_c) begin
                    opcode_d      = cmd.cmd_data[31:24];
                    length_d      = cmd.cmd_data[15:0];
                    payload_len_d = cmd.cmd_data[15:0];
                    count_d       = '0;
                    if (cmd.cmd_data[15:0] == '0) begin
                        state_d = DISPATCH;
                        // Zero-length command: start decoded straight from the header
                        if (is_unit_op(cmd.cmd_data[31:24], NUM_UNITS)) begin
                            start_d    = NUM_UNITS'(1) << (cmd.cmd_data[31:24] - OP_UNIT_BASE);
                            unit_sel_d = start_d;
                        end
                    end else if (cmd.cmd_data[15:0] > LEN_W'(MAX_PAYLOAD)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = READ;
                    end
                end
            end

            READ: begin
                if (hs_c) begin
                    for (int unsigned i = 0; i < MAX_PAYLOAD; i++) begin
                        if (LEN_W'(i) == count_q) begin
                            payload_d[i] = cmd.cmd_data;
                        end
                    end
                    count_d = count_q + LEN_W'(1);
                    if (count_d == length_q) begin
                        state_d = DISPATCH;
                        if (is_unit_op(opcode_q, NUM_UNITS)) begin
                            start_d    = NUM_UNITS'(1) << (opcode_q - OP_UNIT_BASE);
                            unit_sel_d = start_d;
                        end
                    end
                end
            end

            DRAIN: begin
                if (hs_c) begin
                    count_d = count_q + LEN_W'(1);
                    if (count_d == length_q) begin
                        state_d     = IDLE;
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_OVERSIZE;
                    end
                end
            end

            DISPATCH: begin
                state_d = IDLE;
                if (is_unit_op(opcode_q, NUM_UNITS)) begin
                    state_d = WAIT;
                end else if (opcode_q == OP_SET_COLOR) begin
                    if (length_q == LEN_SET_COLOR) begin
                        color_d = payload_q[0];
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_BAD_LEN;
                    end
                end else if (opcode_q == OP_SET_VIEWPORT) begin
                    if (length_q == LEN_SET_VIEWPORT) begin
                        viewport_d.xmin = payload_q[0];
                        viewport_d.ymin = payload_q[1];
                        viewport_d.xmax = payload_q[2];
                        viewport_d.ymax = payload_q[3];
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_BAD_LEN;
                    end
                end else begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_UNKNOWN_OP;
                end
            end

            WAIT: begin
                // Done takes priority over a simultaneous timeout
                if (done_hit_c) begin
                    state_d = IDLE;
                end else if (wd_expire) begin
                    state_d     = IDLE;
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE) || (state_d == READ) || (state_d == DRAIN);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            opcode_q      <= '0;
            length_q      <= '0;
            count_q       <= '0;
            payload_q     <= '0;
            payload_len_q <= '0;
            color_q       <= '0;
            viewport_q    <= '0;
            start_q       <= '0;
            unit_sel_q    <= '0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b0;
            err_valid_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            length_q      <= length_d;
            count_q       <= count_d;
            payload_q     <= payload_d;
            payload_len_q <= payload_len_d;
            color_q       <= color_d;
            viewport_q    <= viewport_d;
            start_q       <= start_d;
            unit_sel_q    <= unit_sel_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            err_valid_q   <= err_valid_d;
            err_code_q    <= err_code_d;
        end
    end

    assign cmd.cmd_ready  = ready_q;
    assign unit_start     = start_q;
    assign payload        = payload_q;
    assign payload_len    = payload_len_q;
    assign current_color  = color_q;
    assign viewport       = viewport_q;
    assign busy           = busy_q;
    assign err_valid      = err_valid_q;
    assign err_code       = err_code_q;

endmodule

// File: doc/cmd_dispatch.md
# cmd_dispatch

Parametrised command front-end for the graphics accelerator: consumes a 32-bit valid/ready command word stream, buffers up to `MAX_PAYLOAD` payload words, and dispatches each command to one of `NUM_UNITS` action units or to the graphics-state registers. It replaces the fixed three-unit command processor. It adds unit-count/payload-depth generality, oversize-payload draining, per-command done timeout, and error reporting. It sits between the host command FIFO and the clear/raster/SIMD units.

## Interface
- `MAX_PAYLOAD`, 6, payload buffer depth in words (≥4)
- `NUM_UNITS`, 3, number of action units (1–15)
- `TIMEOUT_CYCLES`, 65535, max cycles waiting for `unit_done`; 0 disables the timeout
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `cmd_valid`  in  1  command word valid
- `cmd_data`  in  32  command word
- `cmd_ready`  out  1  word accepted when `cmd_valid && cmd_ready`
- `unit_start`  out  NUM_UNITS  one-hot, single-cycle start pulse
- `unit_done`  in  NUM_UNITS  per-unit completion pulse
- `payload`  out  32*MAX_PAYLOAD  buffered payload; word i at bits [32i+31:32i]
- `payload_len`  out  16  length of the current command
- `current_color`  out  32  graphics-state colour
- `viewport`  out  128  {ymax, xmax, ymin, xmin}, xmin in [31:0]
- `busy`  out  1  high in any state but IDLE
- `err_valid`  out  1  single-cycle error pulse
- `err_code`  out  3  last error code, held until the next error

## Operation
- Header word: opcode = [31:24]; length = [15:0]; bits [23:16] are ignored.
- Opcode map:
  - 0x01+i for i < NUM_UNITS: start unit i.
  - 0x10 SET_COLOR: requires length 1.
  - 0x11 SET_VIEWPORT: requires length 4.
  - Any other opcode is unknown.
- States:
  - IDLE: `cmd_ready`=1. An accepted header latches opcode and length and clears the word count.
    - length 0 → DISPATCH.
    - length > MAX_PAYLOAD → DRAIN.
    - otherwise → READ.
  - READ: `cmd_ready`=1. Each accepted word is written to `payload[count]` and count increments. The word that makes count == length moves the FSM to DISPATCH.
  - DRAIN: `cmd_ready`=1. Accepted words are discarded and counted. The last one moves the FSM to IDLE with error 2.
  - DISPATCH: lasts one cycle; `cmd_ready`=0.
    - Unit opcode: `unit_start[i]` high this cycle, then → WAIT.
    - State opcode with correct length: register write, then → IDLE.
    - State opcode with wrong length: no write, error 3, → IDLE.
    - Unknown opcode: error 1, → IDLE.
  - WAIT: `cmd_ready`=0.
    - `unit_done[i]` for the dispatched unit → IDLE. Done bits of other units are ignored.
    - Timeout counter reaching TIMEOUT_CYCLES → IDLE with error 4.
- Error codes: 0 none, 1 unknown opcode, 2 oversize payload, 3 bad length, 4 timeout.
- `payload` and `payload_len` hold their values from the last READ until the next header. `payload` words at or above the length keep stale data.

## Timing
- Reset values:
  - `cmd_ready`=0 during reset; it rises to 1 once IDLE is active.
  - `unit_start`, `busy`, `err_valid`, `err_code`, `payload`, `payload_len`, `current_color`, `viewport` are all 0.
- Reset mid-operation: outputs clear immediately (asynchronous) and the FSM returns to IDLE. There is no pending start and no error.
- A length-N unit command with back-to-back words reaches DISPATCH in N+1 cycles after the header cycle. `unit_start` is high in cycle N+1.
- A zero-length unit command pulses `unit_start` the cycle after the header is accepted.
- `unit_done` is sampled starting one cycle after `unit_start`. A done asserted in the same cycle as start is ignored.
- IDLE is re-entered the cycle after done is sampled. A new header may be accepted in that cycle.
- State writes: `current_color`/`viewport` update at the end of the DISPATCH cycle and are visible two cycles after the last payload word.
- Timeout counter: reset on entry to WAIT; it increments each WAIT cycle without done. If done and timeout occur in the same cycle, done wins and no error is raised.
- `err_valid` pulses in the cycle the FSM returns to IDLE, and `err_code` updates in the same cycle.
- `cmd_valid` low stalls READ/DRAIN indefinitely; there is no timeout on input.

## Structure
- Package `cmd_pkg`: opcode constants (OP_UNIT_BASE, OP_SET_COLOR, OP_SET_VIEWPORT), error-code constants, FSM state enum (IDLE, READ, DRAIN, DISPATCH, WAIT).
- Sub-module `cmd_watchdog`:
  - Inputs: clear, enable.
  - Output: expire.
  - Width: $clog2(TIMEOUT_CYCLES+1).
  - TIMEOUT_CYCLES=0 ties expire low.

## Test plan
- SET_COLOR header 0x10000001 followed by 0xFF00FF00 → `current_color`=0xFF00FF00 two cycles after the payload word; no `unit_start`; `busy` returns to 0.
- SET_VIEWPORT header with length 4 and words 0,0,639,479 → `viewport`={479,639,0,0}. Repeating with length 3 → error 3, viewport unchanged.
- Header 0x02000000 with NUM_UNITS=3 → `unit_start`=3'b010 for one cycle. Done given 5 cycles later → IDLE the following cycle; the next header is accepted.
- Header 0x01000009 with MAX_PAYLOAD=6 → 9 words accepted and discarded, error 2 pulses, `payload` unchanged.
- TIMEOUT_CYCLES=16, unit 0 started and done never asserted → error 4 after 16 WAIT cycles, then IDLE. Opcode 0x7F → error 1.
- Reset asserted in WAIT and in mid-READ → all outputs 0 immediately; after release, a fresh header dispatches normally.
